// File: rtl/efi_pkg.sv
// Shared types and constants for the EFI fuel-timing core.
//   stroke_t     : four-stroke cycle position of one cylinder
//   INIT_STROKE  : stroke each cylinder takes when the engine starts
//                  (firing order 1-3-4-2)
//   fic_state_t  : per-cylinder fuel-injection control state
//   init_stroke(): start stroke for an arbitrary cylinder index
package efi_pkg;

  typedef enum logic [1:0] {
    INTAKE      = 2'd0,
    COMPRESSION = 2'd1,
    POWER       = 2'd2,
    EXHAUST     = 2'd3
  } stroke_t;

  localparam stroke_t INIT_STROKE [4] = '{INTAKE, COMPRESSION, EXHAUST, POWER};

  typedef enum logic [2:0] {
    FIC_IDLE   = 3'd0,
    FIC_READY  = 3'd1,
    FIC_CAL    = 3'd2,
    FIC_WAIT   = 3'd3,
    FIC_INJECT = 3'd4,
    FIC_UPDATE = 3'd5
  } fic_state_t;

  // Cylinders beyond the fourth reuse the 4-cylinder pattern.
  function automatic stroke_t init_stroke(input int cyl);
    return INIT_STROKE[cyl[1:0]];
  endfunction

endpackage

// File: rtl/efi_crank.sv
// Crank position logic.
//   clk, reset           : system clock, synchronous active-high reset
//   ckp                  : raw crank sensor level (asynchronous)
//   on                   : engine enable; low clears position state
//   crank_changed        : 1-cycle pulse per counted tooth
//   crank_tick           : 1-cycle pulse when the tooth index reaches 0 or NUM_TEETH/2
//   crank_counter        : tooth index 0..NUM_TEETH-1
//   crank_cycle_counter  : clk cycles of the last tooth period (saturating)
//   cal_rpm              : 1-cycle pulse on wrap to tooth 0
//   cal_btdc             : 1-cycle pulse per tooth once a full period was measured
module efi_crank #(
  parameter int NUM_TEETH           = 60,
  parameter int CYCLE_COUNTER_WIDTH = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ckp,
  input  logic                               on,
  output logic                               crank_changed,
  output logic                               crank_tick,
  output logic [$clog2(NUM_TEETH)-1:0]       crank_counter,
  output logic [CYCLE_COUNTER_WIDTH-1:0]     crank_cycle_counter,
  output logic                               cal_rpm,
  output logic                               cal_btdc
);
  localparam int TW = $clog2(NUM_TEETH);
  localparam int CW = CYCLE_COUNTER_WIDTH;

  logic          ckp_s1_q, ckp_s2_q, ckp_prev_q, on_prev_q;
  logic [TW-1:0] cnt_q, cnt_d, cnt_wrap;
  logic [CW-1:0] period_q, period_d, cyc_q, cyc_d;
  logic          changed_q, changed_d, tick_q, tick_d;
  logic          rpm_q, rpm_d, btdc_q, btdc_d;
  logic          measured_q, measured_d;
  logic          tooth_edge;

  always_comb begin
    // An edge coinciding with the first enabled cycle is dropped.
    tooth_edge = ckp_s2_q & ~ckp_prev_q & on & on_prev_q;
    cnt_wrap   = (cnt_q == TW'(NUM_TEETH - 1)) ? '0 : cnt_q + TW'(1);

    cnt_d      = cnt_q;
    period_d   = (period_q == '1) ? period_q : period_q + CW'(1);
    cyc_d      = cyc_q;
    changed_d  = 1'b0;
    tick_d     = 1'b0;
    rpm_d      = 1'b0;
    btdc_d     = 1'b0;
    measured_d = measured_q;

    if (!on) begin
      cnt_d      = '0;
      period_d   = '0;
      measured_d = 1'b0;
    end else if (tooth_edge) begin
      cnt_d      = cnt_wrap;
      cyc_d      = period_q;
      period_d   = CW'(1);
      changed_d  = 1'b1;
      tick_d     = (cnt_wrap == '0) || (cnt_wrap == TW'(NUM_TEETH / 2));
      rpm_d      = (cnt_wrap == '0);
      // The first period after enable started at an arbitrary point.
      btdc_d     = measured_q;
      measured_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ckp_s1_q   <= 1'b0;
      ckp_s2_q   <= 1'b0;
      ckp_prev_q <= 1'b0;
      on_prev_q  <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      cyc_q      <= '0;
      changed_q  <= 1'b0;
      tick_q     <= 1'b0;
      rpm_q      <= 1'b0;
      btdc_q     <= 1'b0;
      measured_q <= 1'b0;
    end else begin
      ckp_s1_q   <= ckp;
      ckp_s2_q   <= ckp_s1_q;
      ckp_prev_q <= ckp_s2_q;
      on_prev_q  <= on;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      cyc_q      <= cyc_d;
      changed_q  <= changed_d;
      tick_q     <= tick_d;
      rpm_q      <= rpm_d;
      btdc_q     <= btdc_d;
      measured_q <= measured_d;
    end
  end

  assign crank_changed       = changed_q;
  assign crank_tick          = tick_q;
  assign crank_counter       = cnt_q;
  assign crank_cycle_counter = cyc_q;
  assign cal_rpm             = rpm_q;
  assign cal_btdc            = btdc_q;

endmodule

// File: rtl/efi_fic_fsm.sv
// Per-cylinder fuel-injection control FSM.
//   clk, reset       : system clock, synchronous active-high reset
//   on               : engine enable; low forces IDLE and closes the injector at once
//   fic_on           : injection control enable (sequencer running)
//   crank_tick       : half-revolution pulse
//   stroke           : this cylinder's current stroke
//   allow_injection  : this cylinder's injection window
//   done             : injector driver finished
//   inject           : injector open
//   cal_injection    : 1-cycle request to compute injection time
//   update_table     : 1-cycle request to update the fuel table
//   fuel_pump        : pump enable, high in every state but IDLE
module efi_fic_fsm import efi_pkg::*; (
  input  logic    clk,
  input  logic    reset,
  input  logic    on,
  input  logic    fic_on,
  input  logic    crank_tick,
  input  stroke_t stroke,
  input  logic    allow_injection,
  input  logic    done,
  output logic    inject,
  output logic    cal_injection,
  output logic    update_table,
  output logic    fuel_pump
);
  fic_state_t state_q, state_d;

  always_comb begin
    state_d       = state_q;
    inject        = 1'b0;
    cal_injection = 1'b0;
    update_table  = 1'b0;
    fuel_pump     = (state_q != FIC_IDLE);
    case (state_q)
      FIC_IDLE:  if (fic_on) state_d = FIC_READY;
      // Calculation is requested for the intake stroke that follows exhaust.
      FIC_READY: if (crank_tick && stroke == EXHAUST) state_d = FIC_CAL;
      FIC_CAL: begin
        cal_injection = 1'b1;
        state_d       = FIC_WAIT;
      end
      FIC_WAIT:  if (allow_injection) state_d = FIC_INJECT;
      FIC_INJECT: begin
        // Gated by on so the injector closes without waiting for the clock.
        inject = on;
        if (done || !allow_injection) state_d = FIC_UPDATE;
      end
      FIC_UPDATE: begin
        update_table = 1'b1;
        state_d      = FIC_READY;
      end
      default:   state_d = FIC_IDLE;
    endcase
    if (!on) state_d = FIC_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FIC_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/efi_stroke_seq.sv
// Stroke sequencer: advances every cylinder's stroke on each half revolution.
//   clk, reset       : system clock, synchronous active-high reset
//   on               : engine enable; low clears running and strokes
//   crank_tick       : half-revolution pulse
//   running          : set on the first tick after enable
//   stroke           : packed 2-bit stroke per cylinder
//   allow_injection  : cylinder in INTAKE while running
//   allow_ignition   : cylinder in COMPRESSION while running
module efi_stroke_seq import efi_pkg::*; #(
  parameter int CYLINDERS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   on,
  input  logic                   crank_tick,
  output logic                   running,
  output logic [2*CYLINDERS-1:0] stroke,
  output logic [CYLINDERS-1:0]   allow_injection,
  output logic [CYLINDERS-1:0]   allow_ignition
);
  logic    running_q, running_d;
  stroke_t stroke_q [CYLINDERS];
  stroke_t stroke_d [CYLINDERS];

  always_comb begin
    running_d = running_q;
    for (int i = 0; i < CYLINDERS; i++) stroke_d[i] = stroke_q[i];
    if (!on) begin
      running_d = 1'b0;
      for (int i = 0; i < CYLINDERS; i++) stroke_d[i] = INTAKE;
    end else if (crank_tick) begin
      running_d = 1'b1;
      // First tick loads the start pattern; later ticks advance mod 4.
      for (int i = 0; i < CYLINDERS; i++)
        stroke_d[i] = running_q ? stroke_t'(stroke_q[i] + 2'd1) : init_stroke(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_q <= 1'b0;
      for (int i = 0; i < CYLINDERS; i++) stroke_q[i] <= INTAKE;
    end else begin
      running_q <= running_d;
      stroke_q  <= stroke_d;
    end
  end

  assign running = running_q;

  genvar gi;
  generate
    for (gi = 0; gi < CYLINDERS; gi++) begin : g_cyl
      assign stroke[2*gi +: 2]   = stroke_q[gi];
      assign allow_injection[gi] = running_q & (stroke_q[gi] == INTAKE);
      assign allow_ignition[gi]  = running_q & (stroke_q[gi] == COMPRESSION);
    end
  endgenerate

endmodule

// File: rtl/efi_fuel_timing.sv
// Crank-synchronous fuel-injection timing core.
//   clk, reset           : system clock, synchronous active-high reset
//   ckp, on, done        : crank sensor, engine enable, per-cylinder driver done
//   crank_*              : tooth pulse/tick, tooth index, last tooth period
//   cal_rpm, cal_btdc    : recalculation requests
//   stroke               : packed per-cylinder stroke
//   allow_injection/ignition, fic_on, ic_on : per-cylinder windows/enables
//   inject, cal_injection, update_table, fuel_pump : per-cylinder FSM outputs
module efi_fuel_timing import efi_pkg::*; #(
  parameter int NUM_TEETH           = 60,
  parameter int CYLINDERS           = 4,
  parameter int CYCLE_COUNTER_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ckp,
  input  logic                           on,
  input  logic [CYLINDERS-1:0]           done,
  output logic                           crank_tick,
  output logic                           crank_changed,
  output logic [$clog2(NUM_TEETH)-1:0]   crank_counter,
  output logic [CYCLE_COUNTER_WIDTH-1:0] crank_cycle_counter,
  output logic                           cal_rpm,
  output logic                           cal_btdc,
  output logic [2*CYLINDERS-1:0]         stroke,
  output logic [CYLINDERS-1:0]           allow_injection,
  output logic [CYLINDERS-1:0]           allow_ignition,
  output logic [CYLINDERS-1:0]           fic_on,
  output logic [CYLINDERS-1:0]           ic_on,
  output logic [CYLINDERS-1:0]           inject,
  output logic [CYLINDERS-1:0]           cal_injection,
  output logic [CYLINDERS-1:0]           update_table,
  output logic [CYLINDERS-1:0]           fuel_pump
);
  logic running;

  efi_crank #(
    .NUM_TEETH          (NUM_TEETH),
    .CYCLE_COUNTER_WIDTH(CYCLE_COUNTER_WIDTH)
  ) u_crank (
    .clk                (clk),
    .reset              (reset),
    .ckp                (ckp),
    .on                 (on),
    .crank_changed      (crank_changed),
    .crank_tick         (crank_tick),
    .crank_counter      (crank_counter),
    .crank_cycle_counter(crank_cycle_counter),
    .cal_rpm            (cal_rpm),
    .cal_btdc           (cal_btdc)
  );

  efi_stroke_seq #(.CYLINDERS(CYLINDERS)) u_stroke (
    .clk            (clk),
    .reset          (reset),
    .on             (on),
    .crank_tick     (crank_tick),
    .running        (running),
    .stroke         (stroke),
    .allow_injection(allow_injection),
    .allow_ignition (allow_ignition)
  );

  assign fic_on = {CYLINDERS{running}};
  assign ic_on  = {CYLINDERS{running}};

  genvar gi;
  generate
    for (gi = 0; gi < CYLINDERS; gi++) begin : g_fic
      efi_fic_fsm u_fic (
        .clk            (clk),
        .reset          (reset),
        .on             (on),
        .fic_on         (fic_on[gi]),
        .crank_tick     (crank_tick),
        .stroke         (stroke_t'(stroke[2*gi +: 2])),
        .allow_injection(allow_injection[gi]),
        .done           (done[gi]),
        .inject         (inject[gi]),
        .cal_injection  (cal_injection[gi]),
        .update_table   (update_table[gi]),
        .fuel_pump      (fuel_pump[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_efi_fuel_timing.sv
// Directed bench for efi_fuel_timing: 60-tooth wheel, 8-cycle tooth period,
// 6-bit period counter so saturation is reachable in a short run.
module tb_efi_fuel_timing;
  localparam int P  = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset, ckp, on;
  logic [3:0]    done;
  logic          crank_tick, crank_changed, cal_rpm, cal_btdc;
  logic [5:0]    crank_counter;
  logic [CW-1:0] crank_cycle_counter;
  logic [7:0]    stroke;
  logic [3:0]    allow_injection, allow_ignition, fic_on, ic_on;
  logic [3:0]    inject, cal_injection, update_table, fuel_pump;

  efi_fuel_timing #(.NUM_TEETH(60), .CYLINDERS(4), .CYCLE_COUNTER_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ckp(ckp), .on(on), .done(done),
    .crank_tick(crank_tick), .crank_changed(crank_changed),
    .crank_counter(crank_counter), .crank_cycle_counter(crank_cycle_counter),
    .cal_rpm(cal_rpm), .cal_btdc(cal_btdc), .stroke(stroke),
    .allow_injection(allow_injection), .allow_ignition(allow_ignition),
    .fic_on(fic_on), .ic_on(ic_on), .inject(inject),
    .cal_injection(cal_injection), .update_table(update_table),
    .fuel_pump(fuel_pump)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  bit ckp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled by the caller at the falling edge.
  task automatic step();
    @(negedge clk);
    if (ckp_en) begin
      ckp   = (phase < P / 2);
      phase = (phase + 1) % P;
    end
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return crank_tick;
      1:       return !allow_injection[2];
      2:       return inject[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_until(input string tag, input int sel, input int bound);
    int n = 0;
    do begin step(); n++; end while (!probe(sel) && n < bound);
    chk(tag, probe(sel), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int edges, exp_cnt, ticks, rpms, btdcs, guard;
    bit init_chk;

    reset = 1'b1; on = 1'b0; ckp = 1'b0; done = 4'h0;
    repeat (3) step();
    chk("rst_counter", crank_counter, 0);
    chk("rst_stroke", stroke, 0);
    chk("rst_fic_on", fic_on, 0);
    chk("rst_pump", fuel_pump, 0);
    chk("rst_changed", crank_changed, 0);
    chk("rst_cycles", crank_cycle_counter, 0);
    reset = 1'b0;
    step();

    // Tooth edge reaching the detector in the first enabled cycle is dropped.
    ckp = 1'b1; step(); step();
    on = 1'b1; step();
    chk("on_rise_changed", crank_changed, 0);
    chk("on_rise_counter", crank_counter, 0);
    ckp = 1'b0; on = 1'b0; step(); step();

    // One full revolution.
    on = 1'b1; phase = 0; ckp_en = 1'b1;
    edges = 0; exp_cnt = 0; ticks = 0; rpms = 0; btdcs = 0; guard = 0; init_chk = 1'b0;
    while (edges < 60 && guard < 60 * P + 100) begin
      step(); guard++;
      if (init_chk) begin
        chk("init_stroke", stroke, 8'hB4);
        chk("init_fic_on", fic_on, 4'hF);
        chk("init_ic_on", ic_on, 4'hF);
        chk("init_allow_inj", allow_injection, 4'b0001);
        chk("init_allow_ign", allow_ignition, 4'b0010);
        chk("init_pump_idle", fuel_pump, 4'h0);
        init_chk = 1'b0;
      end
      if (crank_changed) begin
        edges++;
        exp_cnt = (exp_cnt + 1) % 60;
        chk("tooth_index", crank_counter, exp_cnt);
        chk("tick_pos", crank_tick, (exp_cnt == 0 || exp_cnt == 30));
        if (crank_tick) begin
          ticks++;
          if (ticks == 1) init_chk = 1'b1;
        end
        rpms  += cal_rpm;
        btdcs += cal_btdc;
      end else begin
        chk("quiet", {crank_tick, cal_rpm, cal_btdc}, 0);
      end
    end
    chk("edges", edges, 60);
    chk("ticks", ticks, 2);
    chk("rpm_pulses", rpms, 1);
    chk("btdc_pulses", btdcs, 59);
    chk("period", crank_cycle_counter, P);
    chk("wrap_counter", crank_counter, 0);

    // Cylinder 2 was in EXHAUST at that tick.
    step();
    chk("t2_stroke", stroke, 8'hC9);
    chk("t2_allow_inj", allow_injection, 4'b0100);
    chk("t2_allow_ign", allow_ignition, 4'b0001);
    chk("t2_cal", cal_injection, 4'b0100);
    chk("t2_inject", inject, 4'h0);
    chk("t2_pump", fuel_pump, 4'hF);
    step();
    chk("wait_cal", cal_injection, 4'h0);
    chk("wait_inject", inject, 4'h0);
    step();
    chk("inj2_open", inject, 4'b0100);

    // done held low: injector stays open through INTAKE, forced end after.
    run_until("allow2_fall", 1, 400);
    chk("inj2_held", inject, 4'b0100);
    chk("t3_update", update_table, 4'h0);
    chk("t3_stroke", stroke, 8'h1E);
    chk("t3_allow_inj", allow_injection, 4'b1000);
    chk("t3_allow_ign", allow_ignition, 4'b0100);
    chk("t3_cal", cal_injection, 4'b1000);
    step();
    chk("forced_inject", inject, 4'h0);
    chk("forced_update", update_table, 4'b0100);
    step();
    chk("update_1cyc", update_table, 4'h0);
    chk("inj3_open", inject, 4'b1000);
    chk("pump_all", fuel_pump, 4'hF);

    // done pulse for 2 cycles, 5 cycles after allow_injection[3] rose.
    step(); step();
    done = 4'hF;
    step();
    chk("done_inject", inject, 4'h0);
    chk("done_update", update_table, 4'b1000);
    step();
    chk("done_update_1cyc", update_table, 4'h0);
    chk("done_ignored", inject, 4'h0);
    chk("done_pump", fuel_pump, 4'hF);
    done = 4'h0;

    // Engine disable while cylinder 1 injects.
    run_until("inj1_open", 2, 400);
    chk("inj1_only", inject, 4'b0010);
    on = 1'b0;
    #1;
    chk("off_inject_now", inject, 4'h0);
    step();
    chk("off_inject", inject, 4'h0);
    chk("off_pump", fuel_pump, 4'h0);
    chk("off_fic_on", fic_on, 4'h0);
    chk("off_counter", crank_counter, 0);
    chk("off_stroke", stroke, 0);
    chk("off_allow", allow_injection, 4'h0);

    on = 1'b1;
    repeat (20) step();
    chk("reen_fic_on", fic_on, 4'h0);
    chk("reen_stroke", stroke, 0);
    chk("reen_pump", fuel_pump, 4'h0);
    run_until("reen_tick", 0, 400);
    chk("reen_tick_index", crank_counter, 30);
    step();
    chk("reen_running", fic_on, 4'hF);
    chk("reen_init", stroke, 8'hB4);

    // Long gap: the period counter saturates and that value is latched.
    ckp_en = 1'b0; ckp = 1'b0;
    repeat (100) step();
    ckp = 1'b1;
    step(); step(); step();
    chk("sat_changed", crank_changed, 1);
    chk("sat_period", crank_cycle_counter, 6'h3F);
    chk("sat_btdc", cal_btdc, 1);

    // Reset mid-revolution.
    ckp = 1'b0; phase = 0; ckp_en = 1'b1;
    repeat (40) step();
    chk("pre_rst_counter_nz", (crank_counter != 0), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_counter", crank_counter, 0);
    chk("mid_rst_cycles", crank_cycle_counter, 0);
    chk("mid_rst_stroke", stroke, 0);
    chk("mid_rst_fic_on", fic_on, 4'h0);
    chk("mid_rst_pump", fuel_pump, 4'h0);
    chk("mid_rst_pulses", {crank_changed, crank_tick, cal_rpm, cal_btdc}, 0);
    chk("mid_rst_inject", inject, 4'h0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
